game_ctrl: RTL and testbench
============================

# game_ctrl

Parametrised game-control FSMD for the bounce game family: it sequences new-game, play, new-ball, pause and game-over phases. It counts lives, keeps a multi-digit BCD score and a session high score, and runs a frame-based wait timer. It sits between the VGA controller's frame tick, the graphics engine's hit/miss strobes and the text overlay. It replaces the inline FSM and the separate timer and counter units, and adds pause, button edge detection, configurable lives, score width and high score.

## Interface
- LIVES, 3: balls per game (1..15).
- DIGITS, 2: BCD score digits (1..4).
- WAIT_FRAMES, 120: frame ticks to wait after a miss (2 s at 60 Hz); must be at least 1.
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-low reset, sampled on rising clk.
- frame_tick  in  1  one-cycle strobe per frame, asserted when x==0 and y==0.
- btn  in  1  jump/start button, level, already debounced.
- pause_btn  in  1  pause button, level, already debounced.
- hit  in  1  one-cycle strobe from graphics: ball struck.
- miss  in  1  one-cycle strobe from graphics: ball lost.
- state  out  3  current phase code, for overlay selection.
- gra_still  out  1  1 = graphics frozen.
- lives  out  4  balls remaining in reserve.
- score  out  4*DIGITS  BCD score; digit 0 is in the LSBs.
- hiscore  out  4*DIGITS  best score since reset.
- new_hiscore  out  1  set in OVER when the last game beat hiscore.

## Operation
- Edge detect: btn_rise = btn & ~btn_q and pause_rise likewise, using one register stage each. Only rising edges advance the FSM. Held buttons never retrigger.
- NEWGAME:
  - gra_still=1, score forced to 0, lives held at LIVES.
  - On btn_rise: go to PLAY, lives <= LIVES-1.
- PLAY:
  - gra_still=0.
  - On hit: score +1, decimal carry across digits, saturating at all nines.
  - On miss:
    - If lives==0, go to OVER; otherwise go to NEWBALL and lives -1.
    - Timer loads WAIT_FRAMES.
  - hit and miss in the same cycle: both act (score increments and miss is processed).
  - pause_rise with no miss: go to PAUSE. Miss has priority over pause.
- PAUSE:
  - gra_still=1; hit and miss ignored; timer frozen.
  - pause_rise: go to PLAY.
- NEWBALL:
  - gra_still=1.
  - When timer==0 and btn_rise: go to PLAY. btn_rise while timer≠0 is discarded and is not remembered.
- OVER:
  - gra_still=1.
  - On the entry cycle: if score > hiscore (unsigned compare of the BCD vectors), hiscore <= score and new_hiscore <= 1.
  - When timer==0: go to NEWGAME and clear new_hiscore.
- Timer:
  - Decrements on frame_tick when nonzero. A load takes priority over a decrement in the same cycle.
  - Width is clog2(WAIT_FRAMES+1).
- Reset (reset==0):
  - state=NEWGAME, lives=LIVES, score=0, hiscore=0, new_hiscore=0, gra_still=1, timer=0, edge registers=0.
  - Reset wins over every event in the same cycle, including mid-game.

## Timing
- All outputs are registered. State, lives, score, hiscore and gra_still update on the clk edge after the qualifying input cycle (1-cycle latency).
- btn_rise is seen 1 cycle after btn rises, so the button-to-state change is 2 cycles.
- Wait duration: OVER/NEWBALL exits no earlier than the WAIT_FRAMES-th frame_tick after the miss cycle.
- hit/miss must be single-cycle. A multi-cycle hit counts once per cycle asserted.

## Structure
- Shared package game_pkg: state codes NEWGAME=3'd0, PLAY=3'd1, NEWBALL=3'd2, OVER=3'd3, PAUSE=3'd4. Also holds the default WAIT_FRAMES constant and the BCD digit width (4).
- Sub-module bcd_counter (parameter DIGITS):
  - Ports: clk, reset, clr, inc, q.
  - Saturates at all nines; clr has priority over inc.
  - Instantiated for the score.
- Timer, edge detectors and FSM live in game_ctrl.

## Test plan
- Reset then btn pulse: state 0->1 two cycles after btn rises; lives=2; gra_still=0.
- With btn held high from reset: exactly one NEWGAME->PLAY transition; after a miss, NEWBALL exit still requires a fresh btn_rise.
- 12 hit pulses in PLAY: score=8'h12. With DIGITS=2 and 105 hits: score saturates at 8'h99.
- Three misses, WAIT_FRAMES=4:
  - Lives go 2->1->0; third miss enters OVER.
  - NEWBALL ignores btn before the 4th frame_tick.
  - OVER returns to NEWGAME on the 4th frame_tick.
  - hiscore=score and new_hiscore=1 during OVER.
- Simultaneous hit+miss with lives=0: score +1 and state OVER in the same update. Simultaneous pause_rise+miss: miss wins.
- pause_rise in PLAY, then hit/miss: ignored, gra_still=1. Second pause_rise: back to PLAY. reset low mid-PAUSE: all outputs return to their reset values the next edge.

Source files
------------

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the bounce-game control slice.
//   state_t              phase codes driven onto game_ctrl.state for the
//                        text overlay (NEWGAME/PLAY/NEWBALL/OVER/PAUSE)
//   BCD_W, BCD_NINE      width and largest value of one BCD digit
//   DEFAULT_WAIT_FRAMES  post-miss wait, 2 s at a 60 Hz frame rate
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int BCD_W               = 4;
    localparam int DEFAULT_WAIT_FRAMES = 120;

    localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

    typedef enum logic [2:0] {
        ST_NEWGAME = 3'd0,
        ST_PLAY    = 3'd1,
        ST_NEWBALL = 3'd2,
        ST_OVER    = 3'd3,
        ST_PAUSE   = 3'd4
    } state_t;

endpackage

// File: rtl/bcd_counter.sv
// ---------------------------------------------------------------------------
// bcd_counter
// Multi-digit decimal up-counter that sticks at all nines.
//   clk    in   system clock
//   reset  in   synchronous, active-low reset
//   clr    in   clear to zero; wins over inc
//   inc    in   add one (one count per cycle asserted)
//   q      out  BCD value, digit 0 in the least significant nibble
// ---------------------------------------------------------------------------
module bcd_counter
    import game_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      inc,
    output logic [BCD_W*DIGITS-1:0]   q
);

    logic [DIGITS-1:0][BCD_W-1:0] cnt_q;
    logic [DIGITS-1:0][BCD_W-1:0] cnt_inc;
    logic                         all_nines;
    logic                         carry;

    // Ripple a decimal carry from digit 0 upward. A digit only changes while
    // a carry is still pending into it.
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        cnt_inc   = cnt_q;
        all_nines = 1'b1;
        carry     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q[i] != BCD_NINE) begin
                all_nines = 1'b0;
            end
            if (carry) begin
                if (cnt_q[i] == BCD_NINE) begin
                    cnt_inc[i] = '0;
                end else begin
                    cnt_inc[i] = cnt_q[i] + 1'b1;
                    carry      = 1'b0;
                end
            end
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !all_nines) begin
            cnt_q <= cnt_inc;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl
// Phase sequencer for the bounce game: new game, play, new ball, pause and
// game over. Counts lives, keeps a BCD score and session high score, and
// times the post-miss wait in frame ticks.
//   clk          in   system clock
//   reset        in   synchronous, active-low reset
//   frame_tick   in   one-cycle strobe per video frame
//   btn          in   start/jump button level (debounced)
//   pause_btn    in   pause button level (debounced)
//   hit          in   one-cycle strobe: ball struck
//   miss         in   one-cycle strobe: ball lost
//   state        out  current phase code (game_pkg::state_t)
//   gra_still    out  1 = graphics frozen (every phase except PLAY)
//   lives        out  balls left in reserve
//   score        out  BCD score, digit 0 in the LSBs
//   hiscore      out  best score since reset
//   new_hiscore  out  in OVER: the game just finished beat the old hiscore
// ---------------------------------------------------------------------------
module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES       = 3,
    parameter int DIGITS      = 2,
    parameter int WAIT_FRAMES = DEFAULT_WAIT_FRAMES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_tick,
    input  logic                      btn,
    input  logic                      pause_btn,
    input  logic                      hit,
    input  logic                      miss,
    output logic [2:0]                state,
    output logic                      gra_still,
    output logic [3:0]                lives,
    output logic [BCD_W*DIGITS-1:0]   score,
    output logic [BCD_W*DIGITS-1:0]   hiscore,
    output logic                      new_hiscore
);

    localparam int SW = BCD_W * DIGITS;
    localparam int TW = $clog2(WAIT_FRAMES + 1);

    localparam logic [TW-1:0] WAIT_LOAD  = TW'(WAIT_FRAMES);
    localparam logic [3:0]    LIVES_INIT = 4'(LIVES);

    state_t         state_q, state_d;
    logic [3:0]     lives_q, lives_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [SW-1:0]  hiscore_q, hiscore_d;
    logic           new_hi_q, new_hi_d;
    logic           gra_still_q;
    logic           over_entry_q, over_entry_d;

    // Button edge detectors. The rise pulse itself is registered, so a press
    // reaches the FSM one cycle after the button goes high.
    logic btn_q, btn_rise;
    logic pause_q, pause_rise;

    logic score_clr, score_inc;

    bcd_counter #(
        .DIGITS (DIGITS)
    ) u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .q     (score)
    );

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        timer_d   = timer_q;
        hiscore_d = hiscore_q;
        new_hi_d  = new_hi_q;
        score_inc = 1'b0;

        // The wait timer runs in every phase but PAUSE; a miss load below
        // overrides this decrement.
        if (state_q != ST_PAUSE && timer_q != '0 && frame_tick) begin
            timer_d = timer_q - 1'b1;
        end

        case (state_q)
            ST_NEWGAME: begin
                lives_d = LIVES_INIT;
                if (btn_rise) begin
                    state_d = ST_PLAY;
                    lives_d = LIVES_INIT - 4'd1;
                end
            end

            ST_PLAY: begin
                // hit counts even in the cycle a miss ends the rally.
                score_inc = hit;
                if (miss) begin
                    timer_d = WAIT_LOAD;
                    if (lives_q == 4'd0) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_NEWBALL;
                        lives_d = lives_q - 4'd1;
                    end
                end else if (pause_rise) begin
                    state_d = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                if (pause_rise) begin
                    state_d = ST_PLAY;
                end
            end

            ST_NEWBALL: begin
                // A press during the wait is simply dropped.
                if (timer_q == '0 && btn_rise) begin
                    state_d = ST_PLAY;
                end
            end

            ST_OVER: begin
                // Compared on the first OVER cycle, once the final hit (if
                // any) has landed in the score counter.
                if (over_entry_q && score > hiscore_q) begin
                    hiscore_d = score;
                    new_hi_d  = 1'b1;
                end
                if (timer_q == '0) begin
                    state_d  = ST_NEWGAME;
                    lives_d  = LIVES_INIT;
                    new_hi_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_NEWGAME;
            end
        endcase

        // Clearing on the way into NEWGAME keeps the score at zero for the
        // whole phase rather than one cycle late.
        score_clr    = (state_d == ST_NEWGAME);
        over_entry_d = (state_d == ST_OVER) && (state_q != ST_OVER);
    end

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_NEWGAME;
            lives_q      <= LIVES_INIT;
            timer_q      <= '0;
            hiscore_q    <= '0;
            new_hi_q     <= 1'b0;
            gra_still_q  <= 1'b1;
            over_entry_q <= 1'b0;
            btn_q        <= 1'b0;
            btn_rise     <= 1'b0;
            pause_q      <= 1'b0;
            pause_rise   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            timer_q      <= timer_d;
            hiscore_q    <= hiscore_d;
            new_hi_q     <= new_hi_d;
            gra_still_q  <= (state_d != ST_PLAY);
            over_entry_q <= over_entry_d;
            btn_q        <= btn;
            btn_rise     <= btn & ~btn_q;
            pause_q      <= pause_btn;
            pause_rise   <= pause_btn & ~pause_q;
        end
    end

    assign state       = state_q;
    assign gra_still   = gra_still_q;
    assign lives       = lives_q;
    assign hiscore     = hiscore_q;
    assign new_hiscore = new_hi_q;

endmodule

// File: tb/tb_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_ctrl
// Directed scenarios plus a randomized run for game_ctrl (LIVES=3, DIGITS=2,
// WAIT_FRAMES=4). The reference model tracks the game in plain integers:
// decimal score, life count, frames left to wait, and the button history.
// ---------------------------------------------------------------------------
module tb_game_ctrl;

    localparam int LIVES  = 3;
    localparam int DIGITS = 2;
    localparam int WAIT   = 4;
    localparam int SW     = 4 * DIGITS;
    localparam int MAXS   = 10 ** DIGITS - 1;
    localparam int VW     = 3 + 1 + 4 + SW + SW + 1;

    // phase codes as seen on the state port
    localparam int P_NEWGAME = 0;
    localparam int P_PLAY    = 1;
    localparam int P_NEWBALL = 2;
    localparam int P_OVER    = 3;
    localparam int P_PAUSE   = 4;

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic          frame_tick = 1'b0;
    logic          btn        = 1'b0;
    logic          pause_btn  = 1'b0;
    logic          hit        = 1'b0;
    logic          miss       = 1'b0;
    logic [2:0]    state;
    logic          gra_still;
    logic [3:0]    lives;
    logic [SW-1:0] score;
    logic [SW-1:0] hiscore;
    logic          new_hiscore;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_ctrl #(
        .LIVES       (LIVES),
        .DIGITS      (DIGITS),
        .WAIT_FRAMES (WAIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .btn         (btn),
        .pause_btn   (pause_btn),
        .hit         (hit),
        .miss        (miss),
        .state       (state),
        .gra_still   (gra_still),
        .lives       (lives),
        .score       (score),
        .hiscore     (hiscore),
        .new_hiscore (new_hiscore)
    );

    // ---------------- reference model ----------------
    int m_phase, m_lives, m_wait, m_score, m_hi;
    bit m_newhi, m_just_over;
    bit m_btn_prev, m_btn_press, m_pause_prev, m_pause_press;

    function automatic logic [SW-1:0] to_bcd(input int v);
        logic [SW-1:0] r;
        int            x;
        r = '0;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] model_vec();
        return {3'(m_phase), (m_phase != P_PLAY), 4'(m_lives),
                to_bcd(m_score), to_bcd(m_hi), m_newhi};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {state, gra_still, lives, score, hiscore, new_hiscore};
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        int  nxt;
        int  nlives;
        int  nwait;
        int  nscore;
        bit  press;
        bit  ppress;
        if (!reset) begin
            m_phase = P_NEWGAME; m_lives = LIVES; m_wait = 0; m_score = 0;
            m_hi = 0; m_newhi = 0; m_just_over = 0;
            m_btn_prev = 0; m_btn_press = 0; m_pause_prev = 0; m_pause_press = 0;
            return;
        end
        press  = m_btn_press;
        ppress = m_pause_press;
        m_btn_press   = btn && !m_btn_prev;
        m_btn_prev    = btn;
        m_pause_press = pause_btn && !m_pause_prev;
        m_pause_prev  = pause_btn;

        nxt = m_phase; nlives = m_lives; nscore = m_score; nwait = m_wait;
        if (m_phase != P_PAUSE && m_wait > 0 && frame_tick) nwait = m_wait - 1;
        case (m_phase)
            P_NEWGAME: begin
                nlives = LIVES;
                if (press) begin nxt = P_PLAY; nlives = LIVES - 1; end
            end
            P_PLAY: begin
                if (hit && m_score < MAXS) nscore = m_score + 1;
                if (miss) begin
                    nwait = WAIT;
                    if (m_lives == 0) nxt = P_OVER;
                    else begin nxt = P_NEWBALL; nlives = m_lives - 1; end
                end else if (ppress) nxt = P_PAUSE;
            end
            P_PAUSE:   if (ppress) nxt = P_PLAY;
            P_NEWBALL: if (m_wait == 0 && press) nxt = P_PLAY;
            P_OVER: begin
                if (m_just_over && m_score > m_hi) begin
                    m_hi = m_score; m_newhi = 1;
                end
                if (m_wait == 0) begin
                    nxt = P_NEWGAME; nlives = LIVES; m_newhi = 0;
                end
            end
            default: nxt = P_NEWGAME;
        endcase
        if (nxt == P_NEWGAME) nscore = 0;
        m_just_over = (nxt == P_OVER) && (m_phase != P_OVER);
        m_phase = nxt; m_lives = nlives; m_score = nscore; m_wait = nwait;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pulse_btn();
        btn = 1'b1; tick();
        btn = 1'b0; tick();
    endtask

    task automatic pulse_pause();
        pause_btn = 1'b1; tick();
        pause_btn = 1'b0; tick();
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_tick = 1'b1; tick();
            frame_tick = 1'b0; tick();
        end
    endtask

    task automatic pulse_miss();
        miss = 1'b1; tick();
        miss = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0; tick(); tick();
        checks++;
        if (dut_vec() !== {3'd0, 1'b1, 4'd3, 8'h00, 8'h00, 1'b0})
            $display("FAIL reset_values: got %h expected %h", dut_vec(),
                     {3'd0, 1'b1, 4'd3, 8'h00, 8'h00, 1'b0});
        if (dut_vec() !== {3'd0, 1'b1, 4'd3, 8'h00, 8'h00, 1'b0}) errors++;
        reset = 1'b1; tick();
        checks++;
        if (state !== 3'd0) begin
            errors++; $display("FAIL reset_idle: state %0d expected 0", state);
        end
    endtask

    task automatic test_start();
        btn = 1'b1; tick();
        checks++;
        if (state !== 3'd0) begin
            errors++; $display("FAIL start_latency: state %0d expected 0 one cycle after btn", state);
        end
        btn = 1'b0; tick();
        checks++;
        if ({state, lives, gra_still} !== {3'd1, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL start_play: state/lives/still %h expected %h",
                     {state, lives, gra_still}, {3'd1, 4'd2, 1'b0});
        end
    endtask

    task automatic test_hits();
        repeat (12) begin
            hit = 1'b1; tick();
            hit = 1'b0; tick();
        end
        checks++;
        if (score !== 8'h12) begin
            errors++; $display("FAIL twelve_hits: score %h expected 12", score);
        end
    endtask

    task automatic test_misses();
        logic [VW-1:0] exp_v;
        bit            left;
        pulse_miss();
        checks++;
        if ({state, lives, gra_still} !== {3'd2, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL miss1: state/lives/still %h expected %h",
                     {state, lives, gra_still}, {3'd2, 4'd1, 1'b1});
        end
        frames(3);
        pulse_btn();
        checks++;
        if (state !== 3'd2) begin
            errors++; $display("FAIL early_btn: state %0d expected 2", state);
        end
        frames(1); tick(); tick();
        checks++;
        if (state !== 3'd2) begin
            errors++; $display("FAIL btn_not_remembered: state %0d expected 2", state);
        end
        pulse_btn();
        checks++;
        if ({state, lives} !== {3'd1, 4'd1}) begin
            errors++; $display("FAIL resume1: state/lives %h expected 11", {state, lives});
        end
        pulse_miss();
        checks++;
        if ({state, lives} !== {3'd2, 4'd0}) begin
            errors++; $display("FAIL miss2: state/lives %h expected 20", {state, lives});
        end
        frames(4);
        pulse_btn();
        // final ball: hit and miss together must both act
        hit = 1'b1; miss = 1'b1; tick();
        hit = 1'b0; miss = 1'b0;
        checks++;
        if ({state, score} !== {3'd3, 8'h13}) begin
            errors++; $display("FAIL hit_miss_same: state/score %h expected 313", {state, score});
        end
        tick();
        checks++;
        if ({hiscore, new_hiscore} !== {8'h13, 1'b1}) begin
            errors++;
            $display("FAIL over_hiscore: hiscore/new %h expected %h",
                     {hiscore, new_hiscore}, {8'h13, 1'b1});
        end
        frames(3);
        checks++;
        if (state !== 3'd3) begin
            errors++; $display("FAIL over_wait: state %0d expected 3 after 3 ticks", state);
        end
        frame_tick = 1'b1; tick();
        frame_tick = 1'b0;
        left = 1'b0;
        for (int i = 0; i < 3 && !left; i++) begin
            tick();
            if (state === 3'd0) left = 1'b1;
        end
        checks++;
        if (!left) begin
            errors++; $display("FAIL over_exit: state %0d expected 0 after 4th tick", state);
        end
        exp_v = model_vec();
        checks++;
        if (dut_vec() !== exp_v) begin
            errors++; $display("FAIL after_over: got %h expected %h", dut_vec(), exp_v);
        end
    endtask

    task automatic test_miss_beats_pause();
        pulse_btn();
        pause_btn = 1'b1; tick();
        miss = 1'b1; tick();
        miss = 1'b0; pause_btn = 1'b0;
        checks++;
        if ({state, lives} !== {3'd2, 4'd1}) begin
            errors++; $display("FAIL miss_over_pause: state/lives %h expected 21", {state, lives});
        end
        frames(4);
        pulse_btn();
    endtask

    task automatic test_pause();
        logic [SW-1:0] s0;
        s0 = score;
        pulse_pause();
        checks++;
        if ({state, gra_still} !== {3'd4, 1'b1}) begin
            errors++; $display("FAIL pause_enter: state/still %h expected 9", {state, gra_still});
        end
        hit = 1'b1; tick(); hit = 1'b0;
        pulse_miss();
        frames(2);
        checks++;
        if ({state, gra_still, lives, score} !== {3'd4, 1'b1, 4'd1, s0}) begin
            errors++;
            $display("FAIL pause_ignore: got %h expected %h",
                     {state, gra_still, lives, score}, {3'd4, 1'b1, 4'd1, s0});
        end
        pulse_pause();
        checks++;
        if ({state, gra_still} !== {3'd1, 1'b0}) begin
            errors++; $display("FAIL pause_exit: state/still %h expected 2", {state, gra_still});
        end
        pulse_pause();
        reset = 1'b0; tick();
        checks++;
        if (dut_vec() !== {3'd0, 1'b1, 4'd3, 8'h00, 8'h00, 1'b0}) begin
            errors++; $display("FAIL reset_in_pause: got %h expected %h", dut_vec(),
                               {3'd0, 1'b1, 4'd3, 8'h00, 8'h00, 1'b0});
        end
        reset = 1'b1; tick();
    endtask

    task automatic test_saturate();
        pulse_btn();
        hit = 1'b1;
        repeat (105) tick();
        hit = 1'b0;
        checks++;
        if (score !== 8'h99) begin
            errors++; $display("FAIL saturate: score %h expected 99", score);
        end
    endtask

    task automatic test_held_btn();
        int         starts;
        logic [2:0] prev;
        btn = 1'b1; reset = 1'b0; tick(); tick();
        reset = 1'b1;
        starts = 0; prev = state;
        repeat (20) begin
            tick();
            if (prev === 3'd0 && state === 3'd1) starts++;
            prev = state;
        end
        checks++;
        if (starts != 1 || state !== 3'd1) begin
            errors++; $display("FAIL held_start: starts %0d state %0d expected 1 and 1", starts, state);
        end
        pulse_miss();
        frames(4);
        repeat (10) tick();
        checks++;
        if (state !== 3'd2) begin
            errors++; $display("FAIL held_newball: state %0d expected 2", state);
        end
        btn = 1'b0; tick();
        btn = 1'b1; tick(); tick();
        checks++;
        if (state !== 3'd1) begin
            errors++; $display("FAIL fresh_press: state %0d expected 1", state);
        end
        btn = 1'b0; tick();
    endtask

    task automatic test_random();
        logic [VW-1:0] exp_v;
        int            bad;
        bad = 0;
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 999) != 0);
            hit        = ($urandom_range(0, 99) < 25);
            miss       = ($urandom_range(0, 99) < 3);
            frame_tick = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 15) btn = ~btn;
            if ($urandom_range(0, 99) < 3)  pause_btn = ~pause_btn;
            tick();
            exp_v = model_vec();
            checks++;
            if (dut_vec() !== exp_v) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random_cycle_%0d: got %h expected %h", i, dut_vec(), exp_v);
                bad++;
            end
        end
        reset = 1'b1; hit = 1'b0; miss = 1'b0; frame_tick = 1'b0;
        btn = 1'b0; pause_btn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_hits();
        test_misses();
        test_miss_beats_pause();
        test_pause();
        test_saturate();
        test_held_btn();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
